// File: rtl/gpr_bus_pkg.sv
// Shared encodings for the general purpose register bus sequencer.
package gpr_bus_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'd0,
    OP_LDI = 2'd1,
    OP_ALU = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_IDX_W    = 2;

endpackage

// File: rtl/gpr_onehot_strobe.sv
// Index + enable to a per-register strobe vector; ACT_LOW inverts every bit.
module gpr_onehot_strobe #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2,
  parameter bit ACT_LOW  = 1'b0
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] vec
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign vec[i] = ACT_LOW ^ (en && (idx == IDX_W'(i)));
  end

endmodule

// File: rtl/gpr_bus_sequencer.sv
// Register-bus initiator: sequences source enable, load strobe and release
// for one MOV/LDI/ALU transfer at a time.
module gpr_bus_sequencer
  import gpr_bus_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int ALU_SETTLE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_lhs,
  input  logic [IDX_W-1:0]    req_rhs,
  input  logic [IDX_W-1:0]    req_dst,
  output logic [NUM_REGS-1:0] a_main_n,
  output logic [NUM_REGS-1:0] a_lhs_n,
  output logic [NUM_REGS-1:0] a_rhs_n,
  output logic [NUM_REGS-1:0] load,
  output logic                imm_en,
  output logic                alu_out_en,
  output logic                done,
  output logic                err
);

  localparam logic [IDX_W:0] NREGS_W   = (IDX_W+1)'(NUM_REGS);
  localparam logic [3:0]     SETTLE_LD = 4'(ALU_SETTLE - 1);

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NREGS_W;
  endfunction

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  src_q, src_d, lhs_q, lhs_d, rhs_q, rhs_d, dst_q, dst_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, legal, err_d;
  logic              busy_d, main_en, alu_en, imm_d, load_en;
  logic [NUM_REGS-1:0] main_n_d, lhs_n_d, rhs_n_d, load_d;

  always_comb begin
    accept = req_valid && req_ready;
    unique case (op_e'(req_op))
      OP_MOV:  legal = in_range(req_src) && in_range(req_dst);
      OP_LDI:  legal = in_range(req_dst);
      OP_ALU:  legal = in_range(req_lhs) && in_range(req_rhs) && in_range(req_dst);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d = SETUP;
            op_d    = op_e'(req_op);
            src_d   = req_src;
            lhs_d   = req_lhs;
            rhs_d   = req_rhs;
            dst_d   = req_dst;
            cnt_d   = (op_e'(req_op) == OP_ALU) ? SETTLE_LD : 4'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) state_d = STROBE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes straight
  // off a flop and the source stays on through SETUP, STROBE and HOLD.
  always_comb begin
    busy_d  = (state_d != IDLE);
    main_en = busy_d && (op_d == OP_MOV);
    imm_d   = busy_d && (op_d == OP_LDI);
    alu_en  = busy_d && (op_d == OP_ALU);
    load_en = (state_d == STROBE);
  end

  gpr_onehot_strobe #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ACT_LOW(1'b1)) u_main (
    .idx(src_d), .en(main_en), .vec(main_n_d)
  );
  gpr_onehot_strobe #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ACT_LOW(1'b1)) u_lhs (
    .idx(lhs_d), .en(alu_en), .vec(lhs_n_d)
  );
  gpr_onehot_strobe #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ACT_LOW(1'b1)) u_rhs (
    .idx(rhs_d), .en(alu_en), .vec(rhs_n_d)
  );
  gpr_onehot_strobe #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ACT_LOW(1'b0)) u_load (
    .idx(dst_d), .en(load_en), .vec(load_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MOV;
      src_q      <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= 4'd0;
      a_main_n   <= '1;
      a_lhs_n    <= '1;
      a_rhs_n    <= '1;
      load       <= '0;
      imm_en     <= 1'b0;
      alu_out_en <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      a_main_n   <= main_n_d;
      a_lhs_n    <= lhs_n_d;
      a_rhs_n    <= rhs_n_d;
      load       <= load_d;
      imm_en     <= imm_d;
      alu_out_en <= alu_en;
      done       <= (state_d == HOLD);
      err        <= err_d;
      req_ready  <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_gpr_bus_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected strobe snapshots,
// a negedge monitor pops them whenever the sequencer drives anything.
module tb_gpr_bus_sequencer;
  import gpr_bus_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [IW-1:0] req_src = '0, req_lhs = '0, req_rhs = '0, req_dst = '0;
  logic          req_ready;
  logic [NR-1:0] a_main_n, a_lhs_n, a_rhs_n, load;
  logic          imm_en, alu_out_en, done, err;

  gpr_bus_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .ALU_SETTLE(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_dst(req_dst), .a_main_n(a_main_n), .a_lhs_n(a_lhs_n), .a_rhs_n(a_rhs_n),
    .load(load), .imm_en(imm_en), .alu_out_en(alu_out_en), .done(done), .err(err)
  );

  // Three-register instance for the out-of-range index case.
  logic       v3 = 1'b0;
  logic [1:0] op3 = 2'd0, src3 = 2'd0, dst3 = 2'd0;
  logic       rdy3, imm3, alu3, dn3, er3;
  logic [2:0] mn3, ln3, rn3, ld3;

  gpr_bus_sequencer #(.NUM_REGS(3), .IDX_W(2), .ALU_SETTLE(2)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3),
    .req_op(op3), .req_src(src3), .req_lhs(2'd0), .req_rhs(2'd0),
    .req_dst(dst3), .a_main_n(mn3), .a_lhs_n(ln3), .a_rhs_n(rn3),
    .load(ld3), .imm_en(imm3), .alu_out_en(alu3), .done(dn3), .err(er3)
  );

  // Register file + bus model driven by the strobes.
  logic [7:0] rf [NR] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [7:0] bus, lv, rv;

  always_comb begin
    bus = 8'h00;
    lv  = 8'h00;
    rv  = 8'h00;
    for (int i = 0; i < NR; i++) begin
      if (a_lhs_n[i] === 1'b0)  lv  = rf[i];
      if (a_rhs_n[i] === 1'b0)  rv  = rf[i];
      if (a_main_n[i] === 1'b0) bus = rf[i];
    end
    if (imm_en === 1'b1)          bus = 8'hAA;
    else if (alu_out_en === 1'b1) bus = lv + rv;
  end

  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (load[i] === 1'b1) rf[i] <= bus;

  typedef struct {
    int         cyc;
    logic [3:0] mn, ln, rn, ld;
    logic       imm, alu, dn, er, rdy;
  } snap_t;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  logic  rst_seen;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic snap_t mk(input int c, input logic [3:0] mn, ln, rn, ld,
                               input logic imm, alu, dn, er, rdy);
    snap_t s;
    s.cyc = c; s.mn = mn; s.ln = ln; s.rn = rn; s.ld = ld;
    s.imm = imm; s.alu = alu; s.dn = dn; s.er = er; s.rdy = rdy;
    return s;
  endfunction

  snap_t e;
  bit    active, excl_ok;

  always @(negedge clk) begin
    if (rst_seen === 1'b0) begin
      excl_ok = ((32'(a_main_n != 4'hF) + 32'(imm_en) + 32'(alu_out_en)) <= 1) &&
                ($countones(~a_main_n) <= 1) && ($countones(~a_lhs_n) <= 1) &&
                ($countones(~a_rhs_n) <= 1) && ($countones(load) <= 1);
      vectors++;
      if (!excl_ok) begin
        miscompares++;
        $display("FAIL excl cyc=%0d main_n=%b lhs_n=%b rhs_n=%b load=%b imm=%b alu=%b",
                 cyc, a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en);
      end
      active = (a_main_n != 4'hF) || (a_lhs_n != 4'hF) || (a_rhs_n != 4'hF) ||
               (load != 4'h0) || imm_en || alu_out_en || done || err;
      vectors++;
      if (active) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected cyc=%0d main_n=%b lhs_n=%b rhs_n=%b load=%b done=%b err=%b",
                   cyc, a_main_n, a_lhs_n, a_rhs_n, load, done, err);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || a_main_n !== e.mn || a_lhs_n !== e.ln || a_rhs_n !== e.rn ||
              load !== e.ld || imm_en !== e.imm || alu_out_en !== e.alu || done !== e.dn ||
              err !== e.er || req_ready !== e.rdy) begin
            miscompares++;
            $display("FAIL snap got cyc=%0d mn=%b ln=%b rn=%b ld=%b imm=%b alu=%b dn=%b er=%b rdy=%b need cyc=%0d mn=%b ln=%b rn=%b ld=%b imm=%b alu=%b dn=%b er=%b rdy=%b",
                     cyc, a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en, done, err, req_ready,
                     e.cyc, e.mn, e.ln, e.rn, e.ld, e.imm, e.alu, e.dn, e.er, e.rdy);
          end
        end
      end else if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_ready cyc=%0d got %b need 1", cyc, req_ready);
      end
    end
  end

  // nset = cycles in SETUP (0 marks an illegal request); full = expect HOLD.
  task automatic issue(input logic [1:0] op, input logic [1:0] src, lhs, rhs, dst,
                       input logic [3:0] mn, ln, rn, ld, input logic imm, alu,
                       input int nset, input bit full, output int acc);
    int t = 0;
    req_valid = 1'b1; req_op = op; req_src = src; req_lhs = lhs; req_rhs = rhs; req_dst = dst;
    while (req_ready !== 1'b1 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (req_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout got ready=%b need 1", req_ready);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (nset == 0) begin
      exp_q.push_back(mk(acc, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    end else begin
      for (int k = 0; k < nset; k++)
        exp_q.push_back(mk(acc + k, mn, ln, rn, 4'h0, imm, alu, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(acc + nset, mn, ln, rn, ld, imm, alu, 1'b0, 1'b0, 1'b0));
      if (full)
        exp_q.push_back(mk(acc + nset + 1, mn, ln, rn, 4'h0, imm, alu, 1'b1, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending need 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_rf(input int idx, input logic [7:0] want, input string name);
    vectors++;
    if (rf[idx] !== want) begin
      miscompares++;
      $display("FAIL %s got rf[%0d]=%h need %h", name, idx, rf[idx], want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en, done, err, req_ready} !==
        {4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state got mn=%b ln=%b rn=%b ld=%b imm=%b alu=%b dn=%b er=%b rdy=%b",
               a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en, done, err, req_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    issue(OP_MOV, 2'd1, 2'd0, 2'd0, 2'd2, 4'b1101, 4'hF, 4'hF, 4'b0100, 1'b0, 1'b0, 1, 1'b1, acc);
    wait_idle();
    check_rf(2, 8'h21, "mov_1_2");

    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 2'd3, 4'hF, 4'hF, 4'hF, 4'b1000, 1'b1, 1'b0, 1, 1'b1, acc);
    wait_idle();
    check_rf(3, 8'hAA, "ldi_3");

    issue(OP_ALU, 2'd0, 2'd0, 2'd1, 2'd0, 4'hF, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b1, 2, 1'b1, acc);
    wait_idle();
    check_rf(0, 8'h31, "alu_0_1_to_0");

    issue(OP_ILL, 2'd0, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 0, 1'b0, acc);
    wait_idle();

    // Out-of-range source on the three-register instance.
    v3 = 1'b1; op3 = OP_MOV; src3 = 2'd3; dst3 = 2'd0;
    vectors++;
    if (rdy3 !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_ready_pre got %b need 1", rdy3);
    end
    @(posedge clk); #1;
    v3 = 1'b0;
    vectors++;
    if ({er3, rdy3, dn3, imm3, alu3, mn3, ln3, rn3, ld3} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 3'b000}) begin
      miscompares++;
      $display("FAIL oor_err got er=%b rdy=%b dn=%b mn=%b ld=%b need er=1 rdy=1 dn=0 mn=111 ld=000",
               er3, rdy3, dn3, mn3, ld3);
    end
    @(posedge clk); #1;
    vectors++;
    if ({er3, rdy3, mn3, ld3} !== {1'b0, 1'b1, 3'b111, 3'b000}) begin
      miscompares++;
      $display("FAIL oor_after got er=%b rdy=%b mn=%b ld=%b need er=0 rdy=1 mn=111 ld=000",
               er3, rdy3, mn3, ld3);
    end

    issue(OP_MOV, 2'd0, 2'd0, 2'd0, 2'd1, 4'b1110, 4'hF, 4'hF, 4'b0010, 1'b0, 1'b0, 1, 1'b1, acc1);
    issue(OP_MOV, 2'd1, 2'd0, 2'd0, 2'd2, 4'b1101, 4'hF, 4'hF, 4'b0100, 1'b0, 1'b0, 1, 1'b1, acc2);
    vectors++;
    if (acc2 - acc1 != 4) begin
      miscompares++;
      $display("FAIL b2b_spacing got %0d need 4", acc2 - acc1);
    end
    wait_idle();
    check_rf(1, 8'h31, "b2b_mov_0_1");
    check_rf(2, 8'h31, "b2b_mov_1_2");

    // Same register on both operand buses: 8'hAA + 8'hAA wraps to 8'h54.
    issue(OP_ALU, 2'd0, 2'd3, 2'd3, 2'd2, 4'hF, 4'b0111, 4'b0111, 4'b0100, 1'b0, 1'b1, 2, 1'b1, acc);
    wait_idle();
    check_rf(2, 8'h54, "alu_3_3_to_2");

    // Reset lands on the edge that ends STROBE: HOLD and done must never appear.
    issue(OP_MOV, 2'd2, 2'd0, 2'd0, 2'd3, 4'b1011, 4'hF, 4'hF, 4'b1000, 1'b0, 1'b0, 1, 1'b0, acc);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en, done, err, req_ready} !==
        {4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset got mn=%b ln=%b rn=%b ld=%b imm=%b alu=%b dn=%b er=%b rdy=%b",
               a_main_n, a_lhs_n, a_rhs_n, load, imm_en, alu_out_en, done, err, req_ready);
    end
    reset = 1'b0;
    wait_idle();

    issue(OP_MOV, 2'd2, 2'd0, 2'd0, 2'd1, 4'b1011, 4'hF, 4'hF, 4'b0010, 1'b0, 1'b0, 1, 1'b1, acc);
    wait_idle();
    check_rf(1, 8'h54, "fresh_mov_2_1");

    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got %0d pending need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpr_bus_sequencer.md
Name: gpr_bus_sequencer

Overview:
- Initiator/controller side of the general purpose register bus protocol.
- Accepts one register-transfer request at a time over a valid/ready handshake.
- Drives the per-register active-low assert strobes (a_main_n, a_lhs_n, a_rhs_n) and the active-rising load strobes in a fixed, contention-free sequence.
- Sits between the instruction decode stage and the bank of general purpose registers, ALU and immediate driver.

Parameters:
- NUM_REGS, 4, number of general purpose registers controlled.
- IDX_W, 2, register index width; must satisfy 2**IDX_W >= NUM_REGS.
- ALU_SETTLE, 2, cycles the ALU operands are held before the result is loaded (1..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  operation: 0 MOV, 1 LDI, 2 ALU, 3 illegal.
- req_src  input  IDX_W  MOV source register.
- req_lhs  input  IDX_W  ALU left operand register.
- req_rhs  input  IDX_W  ALU right operand register.
- req_dst  input  IDX_W  destination register.
- a_main_n  output  NUM_REGS  per-register main-bus assert, active low.
- a_lhs_n  output  NUM_REGS  per-register LHS-bus assert, active low.
- a_rhs_n  output  NUM_REGS  per-register RHS-bus assert, active low.
- load  output  NUM_REGS  per-register load strobe, active high; the register captures on the rising edge.
- imm_en  output  1  immediate driver enable onto the main bus.
- alu_out_en  output  1  ALU result driver enable onto the main bus.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  one-cycle pulse on an illegal op or out-of-range index.

Behaviour:
- All outputs are registered.
- Reset values, held at reset: a_main_n, a_lhs_n, a_rhs_n all ones; load = 0; imm_en = 0; alu_out_en = 0; done = 0; err = 0; req_ready = 1; state = IDLE.
- States: IDLE, SETUP, STROBE, HOLD.
- A request is accepted on a cycle where req_valid && req_ready. Request fields are latched on acceptance and are ignored at all other times.
- req_ready = 1 only in IDLE. It drops the cycle after acceptance.
- Illegal request: op 3, or any used index >= NUM_REGS.
  - No strobe is asserted and the state stays IDLE.
  - err pulses for 1 cycle, the cycle after acceptance; done stays 0.
  - req_ready stays 1.
- Legal request: IDLE -> SETUP.
- SETUP:
  - The source is enabled.
    - MOV: a_main_n[src] = 0.
    - LDI: imm_en = 1.
    - ALU: a_lhs_n[lhs] = 0, a_rhs_n[rhs] = 0, alu_out_en = 1.
  - MOV/LDI stay in SETUP for 1 cycle.
  - ALU stays in SETUP for ALU_SETTLE cycles, counted by a 4-bit down-counter.
- STROBE (1 cycle): source still enabled; load[dst] = 1.
- HOLD (1 cycle): source still enabled; load = 0; done = 1. The next state is IDLE, where all strobes are released.
- Latency, acceptance edge to done high: MOV/LDI 3 cycles; ALU ALU_SETTLE + 2 cycles.
- Back-to-back throughput: one MOV per 4 cycles.
- Bus exclusivity invariant, every cycle:
  - At most one of {any a_main_n bit low, imm_en, alu_out_en} is active.
  - At most one a_main_n bit, one a_lhs_n bit and one a_rhs_n bit is low.
  - At most one load bit is high.
- load is never high in the same cycle its source first turns on; one setup cycle minimum.
- MOV with src == dst is legal. It performs the full sequence and leaves the register value unchanged.
- ALU with lhs == rhs is legal: the same register drives both buses.
- ALU with dst equal to lhs or rhs is legal. The capture happens on the load edge while the operands are still held.
- Reset asserted mid-operation: at the next edge all strobes are released and the state is IDLE. No done is produced and no partial load pulse remains.
- req_valid arriving while busy is ignored until req_ready is high. The requester must hold the request.

Decomposition:
- Shared package gpr_bus_pkg holds:
  - op encodings OP_MOV = 2'd0, OP_LDI = 2'd1, OP_ALU = 2'd2, OP_ILL = 2'd3;
  - state encodings;
  - default NUM_REGS / IDX_W.
- One natural sub-module, gpr_onehot_strobe: converts an index plus an enable into a NUM_REGS-wide one-hot vector, with an active-low variant. It is instantiated four times (main, lhs, rhs, load).

Test Plan:
- Reset, then MOV src=1 dst=2. Expected:
  - req_ready falls the cycle after acceptance.
  - a_main_n = 4'b1101 for 3 cycles.
  - load = 4'b0100 on the middle cycle.
  - done on cycle 3; all strobes released on cycle 4; req_ready = 1.
- LDI dst=3 with an 8'hAA immediate model. Expected:
  - imm_en high 3 cycles; load = 4'b1000 in STROBE.
  - The register model holds 8'hAA; a_main_n stays 4'hF throughout.
- ALU lhs=0 rhs=1 dst=0 with ALU_SETTLE=2. Expected:
  - a_lhs_n = 4'b1110 and a_rhs_n = 4'b1101 for 4 cycles.
  - load = 4'b0001 on cycle 3; done on cycle 4.
- Illegal op 3, then MOV with src=3 under NUM_REGS=3. Expected: err pulses once each, no strobe changes, req_ready stays 1.
- Two MOVs held valid back-to-back (0->1, then 1->2). Expected:
  - The second is accepted exactly 4 cycles after the first.
  - The exclusivity assertion holds every cycle.
- Reset asserted during STROBE of MOV 2->3. Expected: the next cycle has all assert bits 1, load = 0, done = 0, state IDLE; then a fresh MOV completes normally.
